// File: rtl/reg_file_param.sv
// reg_file_param
//   Parametrised dual-read / single-write register file with byte enables,
//   registered reads (1-cycle latency, write-first bypass), an optional
//   hard-wired zero register and a per-register busy scoreboard used by the
//   pipeline to detect pending writes.
//
// Parameters:
//   DATA_WIDTH  register / data port width, multiple of 8
//   ADDR_WIDTH  address width, DEPTH = 2**ADDR_WIDTH
//   R0_ZERO     nonzero: register 0 reads as 0, ignores writes, never busy
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   READ                read request for both read ports
//   ADDR_R1/ADDR_R2     read addresses
//   DATA_R1/DATA_R2     registered read data
//   BUSY_R1/BUSY_R2     registered busy bits of the read addresses
//   VALID_R             read outputs were updated on the last edge
//   WRITE, ADDR_W       write request and address
//   DATA_W, BE_W        write data and byte enables
//   RSV, ADDR_RSV       reserve request: mark ADDR_RSV busy
module reg_file_param #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned R0_ZERO    = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    READ,
    input  logic [ADDR_WIDTH-1:0]   ADDR_R1,
    input  logic [ADDR_WIDTH-1:0]   ADDR_R2,
    output logic [DATA_WIDTH-1:0]   DATA_R1,
    output logic [DATA_WIDTH-1:0]   DATA_R2,
    output logic                    BUSY_R1,
    output logic                    BUSY_R2,
    output logic                    VALID_R,
    input  logic                    WRITE,
    input  logic [ADDR_WIDTH-1:0]   ADDR_W,
    input  logic [DATA_WIDTH-1:0]   DATA_W,
    input  logic [DATA_WIDTH/8-1:0] BE_W,
    input  logic                    RSV,
    input  logic [ADDR_WIDTH-1:0]   ADDR_RSV
);

    localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam bit          ZERO_R0 = (R0_ZERO != 0);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]      r_busy;

    logic                  w_wr_en;
    logic                  w_rsv_en;
    logic [DATA_WIDTH-1:0] w_wr_merged;
    logic [DEPTH-1:0]      w_busy_nxt;
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;

    // Writes and reservations aimed at a hard-wired zero register vanish here,
    // so nothing downstream needs to special-case them.
    always_comb begin
        w_wr_en  = WRITE && !(ZERO_R0 && (ADDR_W == '0));
        w_rsv_en = RSV && !(ZERO_R0 && (ADDR_RSV == '0));
    end

    // Byte merge of the incoming write onto the current register contents.
    always_comb begin
        w_wr_merged = r_mem[ADDR_W];
        for (int unsigned k = 0; k < NBYTES; k++) begin
            if (BE_W[k]) begin
                w_wr_merged[8*k +: 8] = DATA_W[8*k +: 8];
            end
        end
    end

    // Scoreboard resolution: the write clears first, then a reservation of
    // the same register sets it again, so a new producer supersedes the
    // retiring one.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_en) begin
            w_busy_nxt[ADDR_W] = 1'b0;
        end
        if (w_rsv_en) begin
            w_busy_nxt[ADDR_RSV] = 1'b1;
        end
        if (ZERO_R0) begin
            w_busy_nxt[0] = 1'b0;
        end
    end

    // Read data as it will stand after this edge's write (write-first).
    always_comb begin
        if (ZERO_R0 && (ADDR_R1 == '0)) begin
            w_rd1 = '0;
        end else if (w_wr_en && (ADDR_R1 == ADDR_W)) begin
            w_rd1 = w_wr_merged;
        end else begin
            w_rd1 = r_mem[ADDR_R1];
        end

        if (ZERO_R0 && (ADDR_R2 == '0)) begin
            w_rd2 = '0;
        end else if (w_wr_en && (ADDR_R2 == ADDR_W)) begin
            w_rd2 = w_wr_merged;
        end else begin
            w_rd2 = r_mem[ADDR_R2];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy  <= '0;
            DATA_R1 <= '0;
            DATA_R2 <= '0;
            BUSY_R1 <= 1'b0;
            BUSY_R2 <= 1'b0;
            VALID_R <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_mem[ADDR_W] <= w_wr_merged;
            end
            r_busy <= w_busy_nxt;
            if (READ) begin
                DATA_R1 <= w_rd1;
                DATA_R2 <= w_rd2;
                BUSY_R1 <= w_busy_nxt[ADDR_R1];
                BUSY_R2 <= w_busy_nxt[ADDR_R2];
                VALID_R <= 1'b1;
            end else begin
                VALID_R <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param
//   Directed-vector bench for reg_file_param (default parameters). A
//   behavioural model of the register file predicts the read outputs; a
//   negedge process compares every cycle, and literal expectations pin the
//   model at the interesting steps.
module tb_reg_file_param;

    logic        CLK;
    logic        RST;
    logic        READ;
    logic [4:0]  ADDR_R1;
    logic [4:0]  ADDR_R2;
    logic [31:0] DATA_R1;
    logic [31:0] DATA_R2;
    logic        BUSY_R1;
    logic        BUSY_R2;
    logic        VALID_R;
    logic        WRITE;
    logic [4:0]  ADDR_W;
    logic [31:0] DATA_W;
    logic [3:0]  BE_W;
    logic        RSV;
    logic [4:0]  ADDR_RSV;

    int n_checks;
    int n_fail;
    bit chk_en;

    logic [31:0] m_mem  [32];
    bit          m_busy [32];
    logic [31:0] e_d1, e_d2;
    bit          e_b1, e_b2, e_v;

    reg_file_param #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .R0_ZERO    (1)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .READ     (READ),
        .ADDR_R1  (ADDR_R1),
        .ADDR_R2  (ADDR_R2),
        .DATA_R1  (DATA_R1),
        .DATA_R2  (DATA_R2),
        .BUSY_R1  (BUSY_R1),
        .BUSY_R2  (BUSY_R2),
        .VALID_R  (VALID_R),
        .WRITE    (WRITE),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .BE_W     (BE_W),
        .RSV      (RSV),
        .ADDR_RSV (ADDR_RSV)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        e_d1 = '0; e_d2 = '0; e_b1 = 1'b0; e_b2 = 1'b0; e_v = 1'b0;
    endtask

    // One rising edge as seen by the architecture: write lands, the write
    // retires its register, a reservation marks a register, then reads
    // observe the resulting state. Register 0 is constant zero, never busy.
    task automatic model_edge();
        if (WRITE && ADDR_W != 0) begin
            for (int k = 0; k < 4; k++)
                if (BE_W[k]) m_mem[ADDR_W][8*k +: 8] = DATA_W[8*k +: 8];
            m_busy[ADDR_W] = 1'b0;
        end
        if (RSV && ADDR_RSV != 0) m_busy[ADDR_RSV] = 1'b1;
        if (READ) begin
            e_d1 = m_mem[ADDR_R1];
            e_d2 = m_mem[ADDR_R2];
            e_b1 = m_busy[ADDR_R1];
            e_b2 = m_busy[ADDR_R2];
            e_v  = 1'b1;
        end else begin
            e_v = 1'b0;
        end
    endtask

    task automatic set_in(input bit rd, input logic [4:0] a1, input logic [4:0] a2,
                          input bit wr, input logic [4:0] aw, input logic [31:0] dw,
                          input logic [3:0] be, input bit rsv, input logic [4:0] ar);
        READ = rd; ADDR_R1 = a1; ADDR_R2 = a2;
        WRITE = wr; ADDR_W = aw; DATA_W = dw; BE_W = be;
        RSV = rsv; ADDR_RSV = ar;
    endtask

    // Apply one cycle of stimulus; returns at posedge+1 with outputs settled.
    task automatic step(input bit rd, input logic [4:0] a1, input logic [4:0] a2,
                        input bit wr, input logic [4:0] aw, input logic [31:0] dw,
                        input logic [3:0] be, input bit rsv, input logic [4:0] ar);
        set_in(rd, a1, a2, wr, aw, dw, be, rsv, ar);
        @(posedge CLK);
        if (!RST) model_edge();
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("cyc_data_r1", DATA_R1, e_d1);
            check("cyc_data_r2", DATA_R2, e_d2);
            check("cyc_busy_r1", {31'd0, BUSY_R1}, {31'd0, e_b1});
            check("cyc_busy_r2", {31'd0, BUSY_R2}, {31'd0, e_b2});
            check("cyc_valid_r", {31'd0, VALID_R}, {31'd0, e_v});
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        RST      = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("reset_valid", {31'd0, VALID_R}, 32'd0);
        check("reset_data1", DATA_R1, 32'd0);
        RST    = 1'b0;
        chk_en = 1'b1;

        // Some traffic, then a reset lands while a write to 31 is in flight.
        step(0, 0, 0, 1, 5, 32'h0000_0055, 4'hF, 1, 31);
        step(1, 5, 31, 0, 0, 0, 0, 0, 0);
        check("pre_rst_r5", DATA_R1, 32'h0000_0055);
        check("pre_rst_busy31", {31'd0, BUSY_R2}, 32'd1);
        set_in(1, 5, 31, 1, 31, 32'h1234_5678, 4'hF, 1, 5);
        #2 RST = 1'b1;
        model_reset();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        check("rst_valid", {31'd0, VALID_R}, 32'd0);
        step(1, 5, 31, 0, 0, 0, 0, 0, 0);
        check("rst_read_r5", DATA_R1, 32'd0);
        check("rst_read_r31", DATA_R2, 32'd0);
        check("rst_busy_r1", {31'd0, BUSY_R1}, 32'd0);
        check("rst_busy_r2", {31'd0, BUSY_R2}, 32'd0);
        check("rst_valid_rd", {31'd0, VALID_R}, 32'd1);

        // Plain write then read on both ports.
        step(0, 0, 0, 1, 7, 32'hDEAD_BEEF, 4'hF, 0, 0);
        step(1, 7, 7, 0, 0, 0, 0, 0, 0);
        check("wr7_r1", DATA_R1, 32'hDEAD_BEEF);
        check("wr7_r2", DATA_R2, 32'hDEAD_BEEF);

        // Write-first bypass.
        step(1, 3, 7, 1, 3, 32'h1234_5678, 4'hF, 0, 0);
        check("bypass_r1", DATA_R1, 32'h1234_5678);
        check("bypass_r2", DATA_R2, 32'hDEAD_BEEF);

        // Byte enables, including a merged bypass read.
        step(0, 0, 0, 1, 9, 32'hAABB_CCDD, 4'hF, 0, 0);
        step(0, 0, 0, 1, 9, 32'h1122_3344, 4'b0101, 0, 0);
        step(1, 9, 9, 0, 0, 0, 0, 0, 0);
        check("be_0101", DATA_R1, 32'hAA22_CC44);
        step(1, 9, 3, 1, 9, 32'h5566_7788, 4'b1010, 0, 0);
        check("be_1010_bypass", DATA_R1, 32'h5522_7744);
        step(1, 9, 9, 1, 9, 32'hFFFF_FFFF, 4'b0000, 0, 0);
        check("be_none", DATA_R1, 32'h5522_7744);

        // Register 0 is hard-wired.
        step(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 4'hF, 1, 0);
        step(1, 0, 0, 1, 0, 32'hFFFF_FFFF, 4'hF, 1, 0);
        check("r0_data1", DATA_R1, 32'd0);
        check("r0_data2", DATA_R2, 32'd0);
        check("r0_busy", {31'd0, BUSY_R1}, 32'd0);

        // Scoreboard.
        step(0, 0, 0, 0, 0, 0, 0, 1, 12);
        step(1, 12, 0, 0, 0, 0, 0, 0, 0);
        check("sb_rsv", {31'd0, BUSY_R1}, 32'd1);
        step(1, 12, 12, 1, 12, 32'h0000_CAFE, 4'hF, 1, 12);
        check("sb_rsv_wr_same", {31'd0, BUSY_R1}, 32'd1);
        check("sb_rsv_wr_data", DATA_R2, 32'h0000_CAFE);
        step(1, 12, 12, 0, 0, 0, 0, 1, 12);
        check("sb_rsv_again", {31'd0, BUSY_R2}, 32'd1);
        step(0, 0, 0, 1, 12, 32'h0000_BEEF, 4'b0011, 0, 0);
        step(1, 12, 7, 0, 0, 0, 0, 0, 0);
        check("sb_cleared", {31'd0, BUSY_R1}, 32'd0);
        check("sb_cleared_data", DATA_R1, 32'h0000_BEEF);
        // Write with no byte enables still retires the reservation.
        step(1, 20, 20, 0, 0, 0, 0, 1, 20);
        check("sb_rsv20_bypass", {31'd0, BUSY_R1}, 32'd1);
        step(1, 20, 12, 1, 20, 32'h1111_1111, 4'b0000, 0, 0);
        check("sb_be0_clear", {31'd0, BUSY_R1}, 32'd0);
        check("sb_be0_data", DATA_R1, 32'd0);

        // READ=0: valid drops, outputs hold.
        step(0, 7, 3, 0, 0, 0, 0, 0, 0);
        check("hold_valid", {31'd0, VALID_R}, 32'd0);
        check("hold_data1", DATA_R1, 32'd0);
        check("hold_data2", DATA_R2, 32'h0000_BEEF);

        // Sweep: fill every register, reserve odd ones, read back pairwise.
        for (int i = 1; i < 32; i++)
            step(0, 0, 0, 1, i[4:0], 32'h0101_0101 * i, 4'hF, i[0], i[4:0]);
        for (int i = 0; i < 32; i++)
            step(1, i[4:0], 5'(31 - i), 0, 0, 0, 0, 0, 0);
        check("sweep_last_r1", DATA_R1, 32'h1F1F_1F1F);
        check("sweep_last_busy", {31'd0, BUSY_R1}, 32'd1);
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the 32x32 dual-read register file.
- Configurable data width, register count and byte-granular writes.
- Reads are registered (1-cycle latency) with write-first bypass, and concurrent read and write in the same cycle are legal.
- Adds an optional hard-wired zero register and a per-register busy scoreboard, so the pipeline can detect pending writes (RAW hazards).

Parameters:
- DATA_WIDTH, 32: width of each register and data port; must be a multiple of 8.
- ADDR_WIDTH, 5: address width; DEPTH = 2**ADDR_WIDTH registers.
- R0_ZERO, 1: 1 = register 0 reads as 0, ignores writes and is never busy.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous reset, active-high.
- READ  in  1  read request for both read ports.
- ADDR_R1  in  ADDR_WIDTH  read port 1 address.
- ADDR_R2  in  ADDR_WIDTH  read port 2 address.
- DATA_R1  out  DATA_WIDTH  port 1 read data, registered.
- DATA_R2  out  DATA_WIDTH  port 2 read data, registered.
- BUSY_R1  out  1  busy bit of ADDR_R1, sampled with the read.
- BUSY_R2  out  1  busy bit of ADDR_R2, sampled with the read.
- VALID_R  out  1  DATA_R*/BUSY_R* updated this cycle.
- WRITE  in  1  write request.
- ADDR_W  in  ADDR_WIDTH  write address.
- DATA_W  in  DATA_WIDTH  write data.
- BE_W  in  DATA_WIDTH/8  byte enables for the write; bit k covers DATA_W[8k+7:8k].
- RSV  in  1  reserve request: set the busy bit of ADDR_RSV.
- ADDR_RSV  in  ADDR_WIDTH  register to reserve.

Behaviour:
- Reset, asserted asynchronously while RST=1:
  - all registers = 0, all busy bits = 0;
  - DATA_R1 = DATA_R2 = 0, BUSY_R1 = BUSY_R2 = 0, VALID_R = 0.
  - Reset mid-operation discards any in-flight read or write of that edge.
  - The first operations are accepted on the first rising edge after RST deasserts.
- Write (rising edge, WRITE=1):
  - for each k with BE_W[k]=1, reg[ADDR_W] byte k <= DATA_W byte k; other bytes hold.
  - BE_W=0 performs no data update, but still clears the busy bit.
  - WRITE=1 clears busy[ADDR_W].
  - If R0_ZERO=1 and ADDR_W=0, the write is ignored entirely.
- Read (rising edge, READ=1):
  - DATA_R1 <= value of reg[ADDR_R1] after this edge's write merge; same for port 2.
  - Write-first bypass: if WRITE=1 and ADDR_R*=ADDR_W, DATA_R* returns the byte-merged new value in the same cycle.
  - BUSY_R* <= busy[ADDR_R*] after this edge's reserve/clear resolution, using the same write-first rule.
  - VALID_R <= 1.
  - Latency is 1 cycle from READ sampled to data on DATA_R*.
- READ=0 on an edge: VALID_R <= 0; DATA_R*/BUSY_R* hold their previous values (no Z, no X).
- READ=1 and WRITE=1 together: both are performed; there is no mutual exclusion.
- Both ports may address the same register; both return identical data.
- R0_ZERO=1: reads of address 0 return 0 with BUSY=0.
- Scoreboard (rising edge):
  - RSV=1 sets busy[ADDR_RSV].
  - RSV and WRITE to the same address in the same cycle: the set wins (the new producer supersedes).
  - RSV to R0 with R0_ZERO=1 is ignored.
  - Reserving an already-busy register keeps it busy; no counting.
- Addresses are always in range (DEPTH = 2**ADDR_WIDTH); there is no wrap or out-of-range case.
- No combinational path from inputs to outputs.

Test Plan:
- RST=1 mid-stream, then deassert; READ addr 5/31 -> DATA_R1=DATA_R2=0, BUSY=0, VALID_R=1 one cycle after READ.
- WRITE addr 7 = 32'hDEADBEEF, BE=4'hF; next cycle READ R1=7, R2=7 -> both 32'hDEADBEEF.
- Same-cycle WRITE addr 3 = 32'h12345678 and READ R1=3 -> DATA_R1=32'h12345678 on the next edge (bypass).
- Byte enables:
  - Step: reg 9 = 32'hAABBCCDD, then WRITE 32'h11223344 with BE=4'b0101.
  - Required: READ 9 -> 32'hAA22CC44.
- R0: WRITE addr 0 = 32'hFFFFFFFF, RSV addr 0; READ 0 -> DATA 0, BUSY 0.
- Scoreboard:
  - Step: RSV addr 12, then READ 12.
  - Required: BUSY_R1=1.
  - Step: RSV 12 and WRITE 12 in the same cycle.
  - Required: busy stays 1.
  - Step: WRITE 12 alone, then READ 12.
  - Required: BUSY_R1=0.
  - Step: READ=0.
  - Required: VALID_R=0 and outputs hold.
